// File: rtl/instr_loader_if.sv
// Byte-stream handshake between the boot source and the instruction loader.
// The source drives valid and data. The loader drives ready.
interface instr_loader_if;
    logic       byte_valid_i;
    logic [7:0] byte_i;
    logic       byte_ready_o;

    // Boot source side
    modport master (
        output byte_valid_i,
        output byte_i,
        input  byte_ready_o
    );

    // Loader side
    modport slave (
        input  byte_valid_i,
        input  byte_i,
        output byte_ready_o
    );
endinterface

// File: rtl/instr_loader.sv
// Boot-time instruction loader.
// Parses the frame: sync 0xA5, LEN lo, LEN hi, LEN*4 data bytes, then a checksum byte.
// Assembles little-endian 32-bit words and strobes each word into the core.
// Holds the core in reset until a frame with a valid checksum has been accepted.
module instr_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    instr_loader_if.slave        bus,
    output logic                 wr_instr_en_o,
    output logic [31:0]          wr_instr_o,
    output logic                 cpu_rst_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     word_cnt_o
);

    localparam logic [7:0] SyncByte = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StRun,
        StError
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [31:0]      word_q, word_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_instr_q, wr_instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             ready;
    logic             accept;
    logic [7:0]       in_byte;
    logic [CNT_W-1:0] len_full;
    logic [CNT_W-1:0] cnt_inc;

    // Only RUN refuses bytes. The core owns the machine from then on.
    assign ready            = (state_q != StRun);
    assign bus.byte_ready_o = ready;
    assign accept           = bus.byte_valid_i && ready;
    assign in_byte          = bus.byte_i;

    // Length as it will look once the high byte is latched
    assign len_full = CNT_W'({in_byte, len_q[7:0]});
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // State and datapath registers. Reset wins over everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            len_q      <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            word_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_instr_q <= '0;
            cnt_q      <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            word_q     <= word_d;
            wr_en_q    <= wr_en_d;
            wr_instr_q <= wr_instr_d;
            cnt_q      <= cnt_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic, frame parsing and word assembly
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        word_d     = word_q;
        wr_en_d    = 1'b0;
        wr_instr_d = wr_instr_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            StIdle, StError: begin
                // Anything other than sync is line noise and is dropped
                if (accept && (in_byte == SyncByte)) begin
                    state_d = StLenLo;
                    cnt_d   = '0;
                    csum_d  = '0;
                    idx_d   = '0;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d   = CNT_W'(in_byte);
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = len_full;
                    if ((len_full == '0) || (32'(len_full) > MAX_WORDS)) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d                   = csum_q + in_byte;
                    word_d[{idx_q, 3'b000} +: 8] = in_byte;
                    idx_d                    = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Fourth byte completes the word. It is written straight from the bus
                        // so back-to-back bytes never need a stall.
                        wr_instr_d = {in_byte, word_q[23:0]};
                        wr_en_d    = 1'b1;
                        cnt_d      = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (in_byte == csum_q) ? StRun : StError;
                end
            end
            StRun: begin
                // Terminal until reset
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Core control outputs are registered from the next state.
    // They change on the edge that makes the transition.
    always_comb begin
        cpu_rst_d = (state_d != StRun);
        done_d    = (state_d == StRun);
        err_d     = (state_d == StError);
    end

    assign wr_instr_en_o = wr_en_q;
    assign wr_instr_o    = wr_instr_q;
    assign word_cnt_o    = cnt_q;
    assign cpu_rst_o     = cpu_rst_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader. Frames are sent as byte lists.
// Strobes are recorded at negedge. Expected values are hand-computed constants.
module tb_instr_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en;
    logic [31:0] wr_instr;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [15:0] word_cnt;

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;

    logic [31:0] strb_data[$];
    int          strb_cyc[$];
    int          acc_cyc[$];

    bq_t f1, f1_bad, f2, f2_part, len0, len257, noise, sync_only, f1_rest;

    instr_loader_if bus ();

    instr_loader #(
        .MAX_WORDS(256),
        .CNT_W    (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .wr_instr_en_o(wr_en),
        .wr_instr_o   (wr_instr),
        .cpu_rst_o    (cpu_rst),
        .done_o       (done),
        .err_o        (err),
        .word_cnt_o   (word_cnt)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used for strobe timing
    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe cycle together with its data
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            strb_data.push_back(wr_instr);
            strb_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.byte_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".wr_en"},    32'(wr_en),    32'd0);
        check({tag, ".wr_instr"}, wr_instr,      32'd0);
        check({tag, ".word_cnt"}, 32'(word_cnt), 32'd0);
        check({tag, ".cpu_rst"},  32'(cpu_rst),  32'd1);
        check({tag, ".done"},     32'(done),     32'd0);
        check({tag, ".err"},      32'(err),      32'd0);
        check({tag, ".ready"},    32'(bus.byte_ready_o), 32'd1);
    endtask

    // Send bytes with 1..gmax idle cycles before every byte but the first (gmax=0: back-to-back)
    task automatic send_seq(input bq_t q, input int gmax);
        for (int i = 0; i < q.size(); i++) begin
            if (gmax > 0 && i > 0) begin
                bus.byte_valid_i = 1'b0;
                repeat ($urandom_range(1, gmax)) @(posedge clk);
                #1;
            end
            bus.byte_valid_i = 1'b1;
            bus.byte_i       = q[i];
            @(posedge clk);
            #1;
            acc_cyc.push_back(cyc);
        end
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic clear_logs();
        strb_data.delete();
        strb_cyc.delete();
        acc_cyc.delete();
    endtask

    initial begin
        f1        = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hE3};
        f1_bad    = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hE4};
        sync_only = '{8'hA5};
        f1_rest   = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hE3};
        f2        = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                      8'h93, 8'h00, 8'h50, 8'h00, 8'hF6};
        f2_part   = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
        len0      = '{8'hA5, 8'h00, 8'h00};
        len257    = '{8'hA5, 8'h01, 8'h01};
        noise     = '{8'h00, 8'hFF, 8'h5A};
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;

        // Valid 1-word frame
        do_reset();
        check_reset("rst0");
        clear_logs();
        send_seq(f1, 0);
        check("t1.n_strb",  32'(strb_data.size()), 32'd1);
        if (strb_data.size() > 0) begin
            check("t1.data",    strb_data[0], 32'h0050_0093);
            check("t1.strb_at", 32'(strb_cyc[0]), 32'(acc_cyc[6]));
        end
        check("t1.cnt",     32'(word_cnt), 32'd1);
        check("t1.done",    32'(done), 32'd1);
        check("t1.cpu_rst", 32'(cpu_rst), 32'd0);
        check("t1.ready",   32'(bus.byte_ready_o), 32'd0);
        // Offer bytes while running: nothing may change
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
        check("t1.run_ready", 32'(bus.byte_ready_o), 32'd0);
        check("t1.run_done",  32'(done), 32'd1);
        check("t1.run_cnt",   32'(word_cnt), 32'd1);
        check("t1.run_strb",  32'(strb_data.size()), 32'd1);

        // Bad checksum, then restart
        do_reset();
        clear_logs();
        send_seq(f1_bad, 0);
        check("t2.err",     32'(err), 32'd1);
        check("t2.cpu_rst", 32'(cpu_rst), 32'd1);
        check("t2.done",    32'(done), 32'd0);
        check("t2.ready",   32'(bus.byte_ready_o), 32'd1);
        clear_logs();
        send_seq(sync_only, 0);
        check("t2.err_clr", 32'(err), 32'd0);
        check("t2.cnt_clr", 32'(word_cnt), 32'd0);
        send_seq(f1_rest, 0);
        check("t2.n_strb",  32'(strb_data.size()), 32'd1);
        if (strb_data.size() > 0) check("t2.data", strb_data[0], 32'h0050_0093);
        check("t2.done",    32'(done), 32'd1);
        check("t2.err2",    32'(err), 32'd0);

        // Length rejection: zero and 257
        do_reset();
        clear_logs();
        send_seq(len0, 0);
        check("t3.err0",  32'(err), 32'd1);
        check("t3.strb0", 32'(strb_data.size()), 32'd0);
        do_reset();
        clear_logs();
        send_seq(len257, 0);
        check("t3.err257",  32'(err), 32'd1);
        check("t3.strb257", 32'(strb_data.size()), 32'd0);
        check("t3.done257", 32'(done), 32'd0);

        // Noise in IDLE, then a 2-word frame
        do_reset();
        clear_logs();
        send_seq(noise, 0);
        check("t4.noise_cnt", 32'(word_cnt), 32'd0);
        check("t4.noise_err", 32'(err), 32'd0);
        send_seq(f2, 0);
        check("t4.n_strb", 32'(strb_data.size()), 32'd2);
        if (strb_data.size() == 2) begin
            check("t4.data0", strb_data[0], 32'h0000_0013);
            check("t4.data1", strb_data[1], 32'h0050_0093);
        end
        check("t4.cnt",  32'(word_cnt), 32'd2);
        check("t4.done", 32'(done), 32'd1);

        // Reset mid-load
        do_reset();
        clear_logs();
        send_seq(f2_part, 0);
        do_reset();
        check_reset("t5.rst");
        // Allow a cycle: the discarded partial word must not show up as a strobe
        @(posedge clk);
        #1;
        check("t5.n_strb", 32'(strb_data.size()), 32'd1);
        if (strb_data.size() > 0) check("t5.data0", strb_data[0], 32'h0000_0013);
        clear_logs();
        send_seq(f2, 0);
        check("t5.n_strb2", 32'(strb_data.size()), 32'd2);
        if (strb_data.size() == 2) begin
            check("t5.d0", strb_data[0], 32'h0000_0013);
            check("t5.d1", strb_data[1], 32'h0050_0093);
        end
        check("t5.done", 32'(done), 32'd1);
        check("t5.cnt",  32'(word_cnt), 32'd2);

        // Gapped handshake
        do_reset();
        clear_logs();
        send_seq(f1, 3);
        check("t6.n_strb", 32'(strb_data.size()), 32'd1);
        if (strb_data.size() > 0) begin
            check("t6.data",    strb_data[0], 32'h0050_0093);
            check("t6.strb_at", 32'(strb_cyc[0]), 32'(acc_cyc[6]));
        end
        check("t6.done",    32'(done), 32'd1);
        check("t6.cpu_rst", 32'(cpu_rst), 32'd0);
        check("t6.cnt",     32'(word_cnt), 32'd1);
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
        check("t6.run_ready", 32'(bus.byte_ready_o), 32'd0);
        check("t6.run_done",  32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time instruction loader that sits directly upstream of the CPU core.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives the core's instruction-write port (write enable plus instruction data) and holds the core in reset until a complete frame with a valid checksum has been loaded.
- Releases the core into run mode once the frame is accepted.

Parameters:
- MAX_WORDS, 256: instruction memory depth in words; larger frame lengths are rejected.
- CNT_W, 16: width of the length field and of the word counter.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- byte_valid_i  in  1  source presents a byte
- byte_i  in  8  stream byte
- byte_ready_o  out  1  loader can accept a byte
- wr_instr_en_o  out  1  one-cycle instruction write strobe to the core
- wr_instr_o  out  32  assembled instruction word
- cpu_rst_o  out  1  hold the core in reset (1 = held)
- done_o  out  1  load completed, core running
- err_o  out  1  frame rejected
- word_cnt_o  out  CNT_W  words written so far in the current frame

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high. Reset has priority over every other event.
- Reset values:
  - state IDLE
  - wr_instr_en_o=0, wr_instr_o=0, word_cnt_o=0
  - cpu_rst_o=1, done_o=0, err_o=0
  - internal length, byte index and checksum all 0
- Handshake:
  - A byte is accepted on a rising edge where byte_valid_i && byte_ready_o.
  - byte_ready_o is combinational from the state: 1 in IDLE, LEN_LO, LEN_HI, DATA, CSUM and ERROR; 0 in RUN.
  - Idle cycles between bytes are legal and do not affect the result.
- Frame format: sync 0xA5, LEN[7:0], LEN[15:8], then LEN×4 data bytes (each word LSB first), then one checksum byte.
- Checksum: sum of all data bytes mod 256. Header bytes are excluded.
- State machine:
  - IDLE: an accepted 0xA5 moves to LEN_LO and clears word_cnt, checksum and byte index. Any other byte is discarded.
  - LEN_LO: the accepted byte is latched as LEN low byte; go to LEN_HI.
  - LEN_HI: the accepted byte is latched as LEN high byte. If LEN==0 or LEN>MAX_WORDS, go to ERROR; otherwise go to DATA.
  - DATA: each accepted byte is shifted into the word at position byte_index (0..3) and added to the checksum.
    - On the 4th byte, the word is registered to wr_instr_o and wr_instr_en_o is pulsed high for exactly the next cycle. word_cnt_o increments in that same cycle.
    - wr_instr_o holds its value until the next word.
    - After the last word's 4th byte, go to CSUM. The final write pulse occurs in the first CSUM cycle.
  - CSUM: the accepted byte is compared with the checksum. On match go to RUN; on mismatch go to ERROR.
  - RUN: cpu_rst_o=0 and done_o=1, both registered, starting the cycle after the checksum byte is accepted. No bytes are accepted. The state is left only via rst_i.
  - ERROR: err_o=1, cpu_rst_o=1, done_o=0.
    - An accepted 0xA5 restarts at LEN_LO, clears err_o the following cycle, and clears word_cnt and checksum.
    - Other bytes are discarded.
- Write strobe: at most one wr_instr_en_o pulse per 4 accepted data bytes. Back-to-back bytes (one per cycle) must not drop or merge strobes, so no stall is inserted.
- Reset mid-frame: the partially assembled word is discarded and never written. All outputs return to their reset values on the next edge.
- Words already written to the core are not retracted. A subsequent frame overwrites them from address 0, since the core's write pointer is reset by cpu_rst_o.
- Arithmetic: word_cnt_o and the LEN compare are CNT_W-bit unsigned. The checksum is an 8-bit wrap-around sum.
- Byte index wraps 3→0.

Test Plan:
- Valid 1-word frame: after reset, send A5 01 00 93 00 50 00 E3 back-to-back.
  -> Exactly one wr_instr_en_o pulse with wr_instr_o=0x00500093.
  -> word_cnt_o=1.
  -> cpu_rst_o falls and done_o rises the cycle after E3 is accepted; byte_ready_o=0 thereafter.
- Bad checksum then restart: send A5 01 00 93 00 50 00 E4.
  -> err_o=1, cpu_rst_o=1, done_o=0.
  -> Then send the valid frame of the first test: err_o clears, one write of 0x00500093, done_o=1.
- Length rejection: send A5 00 00.
  -> ERROR after LEN_HI, no write strobe.
  -> After reset, send A5 01 01 (LEN=257 with MAX_WORDS=256): ERROR, no write strobe.
- Noise in IDLE: send 00 FF 5A, then a 2-word frame A5 02 00 13 00 00 00 93 00 50 00 F6.
  -> Noise ignored.
  -> Writes 0x00000013 then 0x00500093; word_cnt_o=2; done_o=1.
- Reset mid-load: send the 2-word frame up to and including byte 93 (first byte of word 2), then assert rst_i for 1 cycle.
  -> Outputs return to reset values; only one strobe (0x00000013) has occurred.
  -> Resending the full frame loads both words.
- Gapped handshake: the valid 1-word frame with byte_valid_i low for 1–3 random cycles between bytes.
  -> Identical strobe, data and done timing relative to the last accepted byte.
  -> No byte is accepted while in RUN.
